// File: rtl/lcd_24_to_8_bits_state_ram_pkg.sv
// Shared constants for the LCD 24-to-8 state RAM and the logic around it.
package lcd_24_to_8_bits_state_ram_pkg;

   localparam int READ_LATENCY          = 2;
   localparam int DEFAULT_ADDRESS_WIDTH = 1;
   localparam int DEFAULT_DATA_WIDTH    = 2;

   // Width of a requester index; never below 1 so a 2-way arbiter still gets a bit.
   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/lcd_24_to_8_bits_rr_arbiter.sv
// Generic round-robin arbiter: one-hot grant searched from last_grant+1,
// pointer moves only when the granted command is actually accepted.
module lcd_24_to_8_bits_rr_arbiter
   import lcd_24_to_8_bits_state_ram_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               enable,
   input  logic               accept,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   last_grant
);

   logic [IDX_W-1:0] grant_idx;
   logic [IDX_W-1:0] sel;
   logic             found;
   int               search_idx;

   // Rotating priority search: first active requester after the last winner.
   always_comb begin
      grant      = '0;
      grant_idx  = '0;
      found      = 1'b0;
      search_idx = 0;
      sel        = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         search_idx = int'(last_grant) + k;
         if (search_idx >= NUM_REQ) search_idx = search_idx - NUM_REQ;
         sel = IDX_W'(search_idx);
         if (enable && !found && req[sel]) begin
            grant[sel] = 1'b1;
            grant_idx  = sel;
            found      = 1'b1;
         end
      end
   end

   // Pointer register; reset value makes requester 0 the first to be served.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         last_grant <= IDX_W'(NUM_REQ - 1);
      else if (accept)
         last_grant <= grant_idx;
   end

endmodule

// File: rtl/lcd_24_to_8_bits_state_ram_arbiter.sv
// Shares the single write port and single read port of the DFA state RAM
// among NUM_REQ requesters and steers read responses back to their issuer.
module lcd_24_to_8_bits_state_ram_arbiter
   import lcd_24_to_8_bits_state_ram_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
   parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [NUM_REQ-1:0]               req_read,
   input  logic [NUM_REQ-1:0]               req_write,
   input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_writedata,
   output logic [NUM_REQ-1:0]               req_waitrequest,
   output logic [NUM_REQ-1:0]               req_readdatavalid,
   output logic [DATA_WIDTH-1:0]            req_readdata,
   output logic [ADDRESS_WIDTH-1:0]         ram_wr_address,
   output logic [DATA_WIDTH-1:0]            ram_wr_writedata,
   output logic                             ram_wr_write,
   input  logic                             ram_wr_waitrequest,
   output logic [ADDRESS_WIDTH-1:0]         ram_rd0_address,
   input  logic [DATA_WIDTH-1:0]            ram_rd0_readdata
);

   localparam int IDX_W = clog2(NUM_REQ);
   localparam int LAT   = READ_LATENCY;

   logic [NUM_REQ-1:0]       active;
   logic [NUM_REQ-1:0]       grant;
   logic [IDX_W-1:0]         last_grant;
   logic [IDX_W-1:0]         grant_idx;
   logic                     any_grant;
   logic                     wr_sel;
   logic                     rd_sel;
   logic [ADDRESS_WIDTH-1:0] sel_address;
   logic [DATA_WIDTH-1:0]    sel_writedata;
   logic [ADDRESS_WIDTH-1:0] rd0_address_q;
   logic [LAT-1:0]           pipe_vld;
   logic [IDX_W-1:0]         pipe_idx [1:LAT-1];

   assign active = req_read | req_write;

   lcd_24_to_8_bits_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .clk        (clk),
      .reset_n    (reset_n),
      .req        (active),
      .enable     (~ram_wr_waitrequest),
      .accept     (any_grant),
      .grant      (grant),
      .last_grant (last_grant)
   );

   // One-hot grant to index for slice selection.
   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (grant[i]) grant_idx = IDX_W'(i);
   end

   assign any_grant       = |grant;
   assign req_waitrequest = ~grant;

   // A requester raising both strobes is served as a write only.
   assign wr_sel        = any_grant & req_write[grant_idx];
   assign rd_sel        = any_grant & ~req_write[grant_idx];
   assign sel_address   = req_address[grant_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
   assign sel_writedata = req_writedata[grant_idx*DATA_WIDTH +: DATA_WIDTH];

   assign ram_wr_write     = wr_sel;
   assign ram_wr_address   = sel_address;
   assign ram_wr_writedata = sel_writedata;
   assign ram_rd0_address  = rd_sel ? sel_address : rd0_address_q;

   // Read address register so the RAM sees a stable address between reads.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         rd0_address_q <= '0;
      else if (rd_sel)
         rd0_address_q <= sel_address;
   end

   // Response pipeline. Stage 0 only needs the valid bit: the pointer moved to
   // the reader's index on the same edge, so last_grant is that index.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pipe_vld <= '0;
         for (int s = 1; s < LAT; s++) pipe_idx[s] <= '0;
      end else begin
         pipe_vld    <= {pipe_vld[LAT-2:0], rd_sel};
         pipe_idx[1] <= last_grant;
         for (int s = 2; s < LAT; s++) pipe_idx[s] <= pipe_idx[s-1];
      end
   end

   // Steer the last pipeline stage onto the one-hot response strobe.
   always_comb begin
      req_readdatavalid = '0;
      if (pipe_vld[LAT-1]) req_readdatavalid[pipe_idx[LAT-1]] = 1'b1;
   end

   assign req_readdata = ram_rd0_readdata;

   // Flag requesters that raise read and write together.
   always @(posedge clk) begin
      if (reset_n)
         assert (!(|(req_read & req_write)))
         else $warning("requester drives read and write together; served as write");
   end

endmodule

// File: tb/tb_lcd_24_to_8_bits_state_ram_arbiter.sv
// Directed, table-driven bench for the state RAM arbiter with a small RAM model.
module tb_lcd_24_to_8_bits_state_ram_arbiter;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] req_read, req_write, req_waitrequest, req_readdatavalid;
   logic [3:0] req_address;
   logic [7:0] req_writedata;
   logic [1:0] req_readdata;
   logic       ram_wr_address;
   logic [1:0] ram_wr_writedata;
   logic       ram_wr_write;
   logic       ram_wr_waitrequest;
   logic       ram_rd0_address;
   logic [1:0] ram_rd0_readdata;

   int n_checks = 0;
   int n_errors = 0;

   lcd_24_to_8_bits_state_ram_arbiter u_dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .req_read           (req_read),
      .req_write          (req_write),
      .req_address        (req_address),
      .req_writedata      (req_writedata),
      .req_waitrequest    (req_waitrequest),
      .req_readdatavalid  (req_readdatavalid),
      .req_readdata       (req_readdata),
      .ram_wr_address     (ram_wr_address),
      .ram_wr_writedata   (ram_wr_writedata),
      .ram_wr_write       (ram_wr_write),
      .ram_wr_waitrequest (ram_wr_waitrequest),
      .ram_rd0_address    (ram_rd0_address),
      .ram_rd0_readdata   (ram_rd0_readdata)
   );

   always #5 clk = ~clk;

   // RAM model: clears while waitrequest, write at the edge, read data 2 cycles after address.
   logic [1:0] mem [2];
   logic       rd_addr_q;
   always @(posedge clk) begin
      if (ram_wr_waitrequest) begin
         mem[0] <= 2'b00;
         mem[1] <= 2'b00;
      end else if (ram_wr_write) begin
         mem[ram_wr_address] <= ram_wr_writedata;
      end
      rd_addr_q        <= ram_rd0_address;
      ram_rd0_readdata <= mem[rd_addr_q];
   end

   typedef struct {
      logic [3:0] rd;
      logic [3:0] wr;
      logic [3:0] addr;
      logic [7:0] wdata;
      logic       ram_wait;
      logic [3:0] e_wait;
      logic       e_wr;
      logic       e_waddr;
      logic [1:0] e_wdata;
      logic       e_rd0;
      logic [3:0] e_rdv;
      logic [1:0] e_rdata;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic [3:0] rd, logic [3:0] wr, logic [3:0] addr,
                               logic [7:0] wd, logic rw, logic [3:0] e_wait, logic e_wr,
                               logic e_waddr, logic [1:0] e_wdata, logic e_rd0,
                               logic [3:0] e_rdv, logic [1:0] e_rdata);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wd; v.ram_wait = rw;
      v.e_wait = e_wait; v.e_wr = e_wr; v.e_waddr = e_waddr; v.e_wdata = e_wdata;
      v.e_rd0 = e_rd0; v.e_rdv = e_rdv; v.e_rdata = e_rdata;
      return v;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs at the falling edge and check outputs just after.
   task automatic apply_vec(input vec_t v, input string tag);
      @(negedge clk);
      req_read           = v.rd;
      req_write          = v.wr;
      req_address        = v.addr;
      req_writedata      = v.wdata;
      ram_wr_waitrequest = v.ram_wait;
      #1;
      chk({tag, " waitrequest"}, 8'(req_waitrequest), 8'(v.e_wait));
      chk({tag, " wr_write"}, 8'(ram_wr_write), 8'(v.e_wr));
      if (v.e_wr) begin
         chk({tag, " wr_address"}, 8'(ram_wr_address), 8'(v.e_waddr));
         chk({tag, " wr_writedata"}, 8'(ram_wr_writedata), 8'(v.e_wdata));
      end
      chk({tag, " rd0_address"}, 8'(ram_rd0_address), 8'(v.e_rd0));
      chk({tag, " readdatavalid"}, 8'(req_readdatavalid), 8'(v.e_rdv));
      if (v.e_rdv != 4'b0000)
         chk({tag, " readdata"}, 8'(req_readdata), 8'(v.e_rdata));
   endtask

   initial begin
      reset_n            = 1'b0;
      ram_wr_waitrequest = 1'b1;
      req_read           = 4'b1111;
      req_write          = 4'b0000;
      req_address        = 4'b0000;
      req_writedata      = 8'h00;

      // Fairness, read-after-write, same-cycle contention; starts with last_grant = 3.
      //                  rd       wr       addr     wdata        w  e_wait  wr a  wd     rd0 rdv      rdata
      vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 8'h00,       0, 4'b1110, 0, 0, 2'b00, 0, 4'b0000, 2'b00));
      vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 8'h00,       0, 4'b1101, 0, 0, 2'b00, 0, 4'b0000, 2'b00));
      vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 8'h00,       0, 4'b1011, 0, 0, 2'b00, 0, 4'b0001, 2'b00));
      vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 8'h00,       0, 4'b0111, 0, 0, 2'b00, 0, 4'b0010, 2'b00));
      vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 8'h00,       0, 4'b1110, 0, 0, 2'b00, 0, 4'b0100, 2'b00));
      vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 8'h00,       0, 4'b1111, 0, 0, 2'b00, 0, 4'b1000, 2'b00));
      vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 8'h00,       0, 4'b1111, 0, 0, 2'b00, 0, 4'b0001, 2'b00));
      vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 8'h00,       0, 4'b1111, 0, 0, 2'b00, 0, 4'b0000, 2'b00));
      vecs.push_back(mk(4'b0000, 4'b0010, 4'b0000, 8'b00001000, 0, 4'b1101, 1, 0, 2'b10, 0, 4'b0000, 2'b00));
      vecs.push_back(mk(4'b0100, 4'b0000, 4'b0000, 8'h00,       0, 4'b1011, 0, 0, 2'b00, 0, 4'b0000, 2'b00));
      vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 8'h00,       0, 4'b1111, 0, 0, 2'b00, 0, 4'b0000, 2'b00));
      vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 8'h00,       0, 4'b1111, 0, 0, 2'b00, 0, 4'b0100, 2'b10));
      vecs.push_back(mk(4'b0000, 4'b1000, 4'b1000, 8'b01000000, 0, 4'b0111, 1, 1, 2'b01, 0, 4'b0000, 2'b00));
      vecs.push_back(mk(4'b1000, 4'b0001, 4'b0000, 8'b00000011, 0, 4'b1110, 1, 0, 2'b11, 0, 4'b0000, 2'b00));
      vecs.push_back(mk(4'b1000, 4'b0000, 4'b0000, 8'h00,       0, 4'b0111, 0, 0, 2'b00, 0, 4'b0000, 2'b00));
      vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 8'h00,       0, 4'b1111, 0, 0, 2'b00, 0, 4'b0000, 2'b00));
      vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 8'h00,       0, 4'b1111, 0, 0, 2'b00, 0, 4'b1000, 2'b11));
      vecs.push_back(mk(4'b0010, 4'b0000, 4'b0010, 8'h00,       0, 4'b1101, 0, 0, 2'b00, 1, 4'b0000, 2'b00));
      vecs.push_back(mk(4'b0100, 4'b0000, 4'b0000, 8'h00,       0, 4'b1011, 0, 0, 2'b00, 0, 4'b0000, 2'b00));
      vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 8'h00,       0, 4'b1111, 0, 0, 2'b00, 0, 4'b0010, 2'b01));
      vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 8'h00,       0, 4'b1111, 0, 0, 2'b00, 0, 4'b0100, 2'b11));

      // Reset with all requesters active, then 3 clearing cycles after release.
      apply_vec(mk(4'b1111, 4'b0000, 4'b0000, 8'h00, 1, 4'b1111, 0, 0, 2'b00, 0, 4'b0000, 2'b00), "rst");
      chk("last_grant after reset", 8'(u_dut.u_arb.last_grant), 8'd3);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++)
         apply_vec(mk(4'b1111, 4'b0000, 4'b0000, 8'h00, 1, 4'b1111, 0, 0, 2'b00, 0, 4'b0000, 2'b00),
                   $sformatf("clear%0d", i));

      for (int i = 0; i < vecs.size(); i++)
         apply_vec(vecs[i], $sformatf("vec%0d", i));

      // Reset mid-operation: reads accepted in T and T+1, reset during T+1.
      apply_vec(mk(4'b0001, 4'b0000, 4'b0000, 8'h00, 0, 4'b1110, 0, 0, 2'b00, 0, 4'b0000, 2'b00), "mid_t0");
      apply_vec(mk(4'b0010, 4'b0000, 4'b0010, 8'h00, 0, 4'b1101, 0, 0, 2'b00, 1, 4'b0000, 2'b00), "mid_t1");
      #2;
      reset_n            = 1'b0;
      ram_wr_waitrequest = 1'b1;
      apply_vec(mk(4'b0000, 4'b0000, 4'b0000, 8'h00, 1, 4'b1111, 0, 0, 2'b00, 0, 4'b0000, 2'b00), "mid_t2");
      chk("last_grant mid reset", 8'(u_dut.u_arb.last_grant), 8'd3);
      apply_vec(mk(4'b0000, 4'b0000, 4'b0000, 8'h00, 1, 4'b1111, 0, 0, 2'b00, 0, 4'b0000, 2'b00), "mid_t3");
      reset_n = 1'b1;
      apply_vec(mk(4'b0000, 4'b0000, 4'b0000, 8'h00, 1, 4'b1111, 0, 0, 2'b00, 0, 4'b0000, 2'b00), "mid_clear");

      // Requester 2 raises read and write: served as write, no response.
      apply_vec(mk(4'b0100, 4'b0100, 4'b0100, 8'b00100000, 0, 4'b1011, 1, 1, 2'b10, 0, 4'b0000, 2'b00), "both");
      apply_vec(mk(4'b0000, 4'b0000, 4'b0000, 8'h00, 0, 4'b1111, 0, 0, 2'b00, 0, 4'b0000, 2'b00), "both_p1");
      apply_vec(mk(4'b0000, 4'b0000, 4'b0000, 8'h00, 0, 4'b1111, 0, 0, 2'b00, 0, 4'b0000, 2'b00), "both_p2");
      apply_vec(mk(4'b0001, 4'b0000, 4'b0001, 8'h00, 0, 4'b1110, 0, 0, 2'b00, 1, 4'b0000, 2'b00), "both_rd");
      apply_vec(mk(4'b0000, 4'b0000, 4'b0000, 8'h00, 0, 4'b1111, 0, 0, 2'b00, 1, 4'b0000, 2'b00), "both_rd1");
      apply_vec(mk(4'b0000, 4'b0000, 4'b0000, 8'h00, 0, 4'b1111, 0, 0, 2'b00, 1, 4'b0001, 2'b10), "both_rd2");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
